// File: rtl/gpu_timing_pkg.sv
// Shared constants, derived-timing helpers and fetch FSM state type for the raster generator.
package gpu_timing_pkg;

  // 640x480@60 Hz with a 25.2 MHz pixel clock
  localparam int unsigned PIX_CLK_HZ = 25_200_000;
  localparam int unsigned H_DISP_DEF = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_DISP_DEF = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;
  localparam int unsigned CW_DEF     = 11;
  localparam int unsigned BPC_DEF    = 4;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // First active count of an axis: porches and sync precede the active region
  function automatic int unsigned axis_start(input int unsigned fp, input int unsigned sync,
                                             input int unsigned bp);
    return fp + sync + bp;
  endfunction

  // Full period of an axis in counts
  function automatic int unsigned axis_total(input int unsigned disp, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return axis_start(fp, sync, bp) + disp;
  endfunction

endpackage

// File: rtl/gpu_sync_axis.sv
// One raster axis: front porch, sync, back porch, active; wraps to 0 after the last count.
module gpu_sync_axis
  import gpu_timing_pkg::*;
#(
  parameter int unsigned DISP = H_DISP_DEF,
  parameter int unsigned FP   = H_FP_DEF,
  parameter int unsigned SYNC = H_SYNC_DEF,
  parameter int unsigned BP   = H_BP_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap_c,
  output logic          sync_c,
  output logic          active_c
);

  localparam int unsigned   TOTAL   = axis_total(DISP, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_LO = CW'(FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(FP + SYNC);
  localparam logic [CW-1:0] START   = CW'(axis_start(FP, SYNC, BP));

  // Count advances only on enabled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (en) cnt <= wrap_c ? '0 : cnt + CW'(1);
  end

  assign wrap_c   = (cnt == LAST);
  assign sync_c   = (cnt >= SYNC_LO) && (cnt < SYNC_HI);
  assign active_c = (cnt >= START);

endmodule

// File: rtl/gpu_timing_gen.sv
// Raster timing generator: counters, two-stage pixel pipeline and line-fetch handshake.
module gpu_timing_gen
  import gpu_timing_pkg::*;
#(
  parameter int unsigned H_DISP     = H_DISP_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_DISP     = V_DISP_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned CW         = CW_DEF,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned BPC        = BPC_DEF,
  parameter int unsigned SCALE_LOG2 = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [BPC-1:0] pix_r,
  input  logic [BPC-1:0] pix_g,
  input  logic [BPC-1:0] pix_b,
  input  logic           line_ack,
  output logic           line_req,
  output logic [CW-1:0]  line_y,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic [BPC-1:0] red,
  output logic [BPC-1:0] green,
  output logic [BPC-1:0] blue,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           frame_start,
  output logic           underrun
);

  localparam int unsigned   H_TOTAL    = axis_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int unsigned   V_TOTAL    = axis_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_START_V  = CW'(axis_start(H_FP, H_SYNC, H_BP));
  localparam logic [CW-1:0] V_START_V  = CW'(axis_start(V_FP, V_SYNC, V_BP));
  localparam logic [CW-1:0] SCALE_MASK = CW'((1 << SCALE_LOG2) - 1);

  if (H_TOTAL > (2 ** CW)) begin : g_h_total_err
    $error("gpu_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (2 ** CW)) begin : g_v_total_err
    $error("gpu_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (SCALE_LOG2 > 2) begin : g_scale_err
    $error("gpu_timing_gen: SCALE_LOG2 must be 0..2");
  end

  logic [CW-1:0] hc, vc;
  logic          h_wrap_c, h_sync_c, h_act_c;
  logic          v_wrap_c, v_sync_c, v_act_c;

  gpu_sync_axis #(.DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_axis (
    .clk(clk), .reset(reset), .en(en),
    .cnt(hc), .wrap_c(h_wrap_c), .sync_c(h_sync_c), .active_c(h_act_c)
  );

  gpu_sync_axis #(.DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_axis (
    .clk(clk), .reset(reset), .en(en & h_wrap_c),
    .cnt(vc), .wrap_c(v_wrap_c), .sync_c(v_sync_c), .active_c(v_act_c)
  );

  logic          vis_c;
  logic [CW-1:0] h_off_c, v_off_c, src_line_c;
  logic          line_first_c;

  assign vis_c        = h_act_c && v_act_c;
  assign h_off_c      = hc - H_START_V;
  assign v_off_c      = vc - V_START_V;
  assign src_line_c   = v_off_c >> SCALE_LOG2;
  assign line_first_c = v_act_c && ((v_off_c & SCALE_MASK) == '0);

  // Set while the counters sit at (0,0), i.e. the first cycle of a frame
  logic origin_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   origin_q <= 1'b1;
    else if (en) origin_q <= h_wrap_c && v_wrap_c;
  end

  // Frame-start pulse; gated by en so it stays one clk wide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= en && origin_q;
  end

  // Stage 1: coordinates and region flags from the counters
  logic vis_q, hs_q, vs_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      vis_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else if (en) begin
      x     <= vis_c ? CW'(h_off_c >> SCALE_LOG2) : '0;
      y     <= vis_c ? src_line_c : '0;
      vis_q <= vis_c;
      hs_q  <= h_sync_c;
      vs_q  <= v_sync_c;
    end
  end

  // Stage 2: pin registers, colour blanked outside the visible region
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (en) begin
      de    <= vis_q;
      red   <= vis_q ? pix_r : '0;
      green <= vis_q ? pix_g : '0;
      blue  <= vis_q ? pix_b : '0;
      hsync <= hs_q ~^ HS_POL;
      vsync <= vs_q ~^ VS_POL;
    end
  end

  fetch_state_e  state_q, state_d;
  logic          line_req_d, underrun_d;
  logic [CW-1:0] line_y_d;

  // Fetch FSM state and handshake output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH_IDLE;
      line_req <= 1'b0;
      line_y   <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_req <= line_req_d;
      line_y   <= line_y_d;
      underrun <= underrun_d;
    end
  end

  // Request at the start of each new source line; ack beats the active-start deadline
  always_comb begin
    state_d    = state_q;
    line_req_d = line_req;
    line_y_d   = line_y;
    underrun_d = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (en && (hc == '0) && line_first_c) begin
          state_d    = FETCH_WAIT;
          line_req_d = 1'b1;
          line_y_d   = src_line_c;
        end
      end
      FETCH_WAIT: begin
        if (line_ack) begin
          state_d    = FETCH_IDLE;
          line_req_d = 1'b0;
        end else if (en && (hc == H_START_V)) begin
          state_d    = FETCH_IDLE;
          line_req_d = 1'b0;
          underrun_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpu_timing_gen.sv
// Bench for gpu_timing_gen: two instances (scale 1x/normal polarity, scale 2x/inverted polarity)
// checked each clk against an arithmetic raster model indexed by the count of enabled cycles.
module tb_gpu_timing_gen;

  localparam int HF = 2, HS = 3, HB = 1, HD = 8;
  localparam int VF = 1, VS = 2, VB = 1, VD = 4;
  localparam int HST = HF + HS + HB, HT = HST + HD;
  localparam int VST = VF + VS + VB, VT = VST + VD;
  localparam int FRAME = HT * VT;
  localparam int CW = 6, BPC = 4;

  logic           clk = 1'b0;
  logic           reset, en;
  logic [BPC-1:0] pix_r, pix_g, pix_b;
  logic [1:0]     ack, line_req_o, hs_o, vs_o, de_o, fs_o, und_o;
  logic [CW-1:0]  ly_o[2], x_o[2], y_o[2];
  logic [BPC-1:0] r_o[2], g_o[2], b_o[2];

  always #5 clk = ~clk;

  gpu_timing_gen #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CW(CW), .HS_POL(1'b0), .VS_POL(1'b0), .BPC(BPC), .SCALE_LOG2(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .line_ack(ack[0]), .line_req(line_req_o[0]), .line_y(ly_o[0]), .x(x_o[0]), .y(y_o[0]),
    .red(r_o[0]), .green(g_o[0]), .blue(b_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
    .de(de_o[0]), .frame_start(fs_o[0]), .underrun(und_o[0])
  );

  gpu_timing_gen #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CW(CW), .HS_POL(1'b1), .VS_POL(1'b1), .BPC(BPC), .SCALE_LOG2(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .line_ack(ack[1]), .line_req(line_req_o[1]), .line_y(ly_o[1]), .x(x_o[1]), .y(y_o[1]),
    .red(r_o[1]), .green(g_o[1]), .blue(b_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
    .de(de_o[1]), .frame_start(fs_o[1]), .underrun(und_o[1])
  );

  // Model state: k = enabled cycles since reset; instance i uses scale 2^i and polarity i
  int k;
  bit pend[2];
  int ly_m[2], wcnt[2], dly[2];
  bit und_m[2];
  bit fs_m;
  int r_m, g_m, b_m;
  int passes = 0;
  int checks = 0;

  function automatic int hc_of(input int n); return n % HT; endfunction
  function automatic int vc_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit vis_of(input int n); return hc_of(n) >= HST && vc_of(n) >= VST; endfunction
  function automatic bit hs_of(input int n); return hc_of(n) >= HF && hc_of(n) < HF + HS; endfunction
  function automatic bit vs_of(input int n); return vc_of(n) >= VF && vc_of(n) < VF + VS; endfunction
  function automatic int x_of(input int n, input int s);
    return vis_of(n) ? (hc_of(n) - HST) >> s : 0;
  endfunction
  function automatic int y_of(input int n, input int s);
    return vis_of(n) ? (vc_of(n) - VST) >> s : 0;
  endfunction

  task automatic model_reset();
    k = 0; fs_m = 1'b0; r_m = 0; g_m = 0; b_m = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; ly_m[i] = 0; und_m[i] = 1'b0; wcnt[i] = 0; dly[i] = 1;
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) begin
      passes++;
    end else begin
      $error("FAIL %s[%0d] got=%0d exp=%0d at en-cycle %0d", tag, i, got, exp, k);
    end
  endtask

  task automatic check_all();
    bit act;
    for (int i = 0; i < 2; i++) begin
      chk("x", i, 32'(x_o[i]), (k >= 1) ? x_of(k - 1, i) : 0);
      chk("y", i, 32'(y_o[i]), (k >= 1) ? y_of(k - 1, i) : 0);
      chk("de", i, 32'(de_o[i]), (k >= 2 && vis_of(k - 2)) ? 1 : 0);
      act = (k >= 2) && hs_of(k - 2);
      chk("hsync", i, 32'(hs_o[i]), (act ^ (i == 0)) ? 1 : 0);
      act = (k >= 2) && vs_of(k - 2);
      chk("vsync", i, 32'(vs_o[i]), (act ^ (i == 0)) ? 1 : 0);
      chk("red", i, 32'(r_o[i]), r_m);
      chk("green", i, 32'(g_o[i]), g_m);
      chk("blue", i, 32'(b_o[i]), b_m);
      chk("line_req", i, 32'(line_req_o[i]), pend[i] ? 1 : 0);
      chk("line_y", i, 32'(ly_o[i]), ly_m[i]);
      chk("underrun", i, 32'(und_o[i]), und_m[i] ? 1 : 0);
      chk("frame_start", i, 32'(fs_o[i]), fs_m ? 1 : 0);
    end
  endtask

  // md: 0 ack after random 1..5 clk delay, 1 never ack, 2 ack on the deadline, 3 random acks
  task automatic step(input bit en_v, input int md);
    int n, vc;
    bit a[2];
    n  = k;
    vc = vc_of(n);
    for (int i = 0; i < 2; i++) begin
      case (md)
        0:       a[i] = pend[i] && (wcnt[i] + 1 == dly[i]);
        1:       a[i] = 1'b0;
        2:       a[i] = pend[i] && en_v && (hc_of(n) == HST);
        default: a[i] = ($urandom_range(0, 2) == 0);
      endcase
    end
    en    = en_v;
    ack   = {a[1], a[0]};
    pix_r = BPC'($urandom);
    pix_g = BPC'($urandom);
    pix_b = BPC'($urandom);
    for (int i = 0; i < 2; i++) begin
      und_m[i] = 1'b0;
      if (!pend[i]) begin
        if (en_v && hc_of(n) == 0 && vc >= VST && ((vc - VST) % (1 << i)) == 0) begin
          pend[i] = 1'b1;
          ly_m[i] = (vc - VST) >> i;
          wcnt[i] = 0;
          dly[i]  = $urandom_range(1, 5);
        end
      end else if (a[i]) begin
        pend[i] = 1'b0;
      end else if (en_v && hc_of(n) == HST) begin
        pend[i]  = 1'b0;
        und_m[i] = 1'b1;
      end else begin
        wcnt[i]++;
      end
    end
    fs_m = en_v && (n % FRAME == 0);
    if (en_v) begin
      if (n >= 1 && vis_of(n - 1)) begin
        r_m = int'(pix_r); g_m = int'(pix_g); b_m = int'(pix_b);
      end else begin
        r_m = 0; g_m = 0; b_m = 0;
      end
      k++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ack = 2'b00;
    pix_r = '0; pix_g = '0; pix_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    repeat (2 * FRAME) step(1'b1, 0);
    repeat (FRAME) step(1'b1, 1);
    repeat (FRAME) step(1'b1, 2);
    repeat (3 * FRAME) step(1'($urandom_range(0, 1)), 3);
    for (int j = 0; j < 2 * FRAME; j++) step(j % 2 == 0, 0);

    repeat (FRAME + 60) step(1'b1, 0);
    #1 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
    repeat (FRAME + 20) step(1'b1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
